// File: rtl/wb_port_arbiter_pkg.sv
// Shared CPU types for the writeback port arbiter: register-file widths and
// the {valid, rd, value} write record used by both writeback and multdiv paths.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     value;
  } md_entry_t;

  typedef md_entry_t wb_req_t;

endpackage

// File: rtl/md_fifo2.sv
// Two-entry in-order buffer for multdiv results. Entries whose rd matches
// kill_rd are dropped; survivors are kept compacted toward slot 0 (the head).
module md_fifo2
  import wb_port_arbiter_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enq,
  input  md_entry_t             enq_data,
  input  logic                  deq,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output logic                  full,
  output logic                  empty,
  output md_entry_t             head
);

  md_entry_t slot_q [2];
  md_entry_t keep_c [2];
  md_entry_t slot_d [2];
  logic      wr_c;

  assign head  = slot_q[0];
  assign empty = ~slot_q[0].valid;
  assign full  = slot_q[1].valid;
  assign wr_c  = enq & ~full;

  // Drop killed/dequeued entries, compact the survivors, then append.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      keep_c[i] = slot_q[i];
      if (kill_en && (slot_q[i].rd == kill_rd)) begin
        keep_c[i].valid = 1'b0;
      end
    end
    if (deq) begin
      keep_c[0].valid = 1'b0;
    end

    slot_d[0] = '0;
    slot_d[1] = '0;
    if (keep_c[0].valid) begin
      slot_d[0] = keep_c[0];
      slot_d[1] = keep_c[1];
    end else begin
      slot_d[0] = keep_c[1];
    end

    if (wr_c) begin
      if (!slot_d[0].valid) begin
        slot_d[0] = enq_data;
      end else begin
        slot_d[1] = enq_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback and
// buffered multdiv results, with a starvation bound and WAW-safe ordering.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_we,
  input  logic                  wb_nop,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_value,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0]     md_value,
  output logic                  md_ready,
  output logic                  stall_wb,
  output logic                  ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0]     data_writeReg
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 4) ? 2 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic             fifo_full;
  logic             fifo_empty;
  md_entry_t        fifo_head;
  md_entry_t        enq_data_c;
  logic             accept_c;
  logic             enq_c;
  logic             wb_req_c;
  logic             force_c;
  logic             wb_grant_c;
  logic             md_grant_c;
  wb_req_t          write_c;
  logic [CNT_W-1:0] starve_q;

  assign wb_req_c   = wb_we & ~wb_nop & (wb_rd != '0);
  assign force_c    = ~fifo_empty & wb_req_c & (starve_q == CNT_MAX);
  assign wb_grant_c = wb_req_c & ~force_c;
  assign md_grant_c = ~fifo_empty & ~wb_grant_c;

  assign md_ready = reset & ~fifo_full;
  assign stall_wb = reset & force_c;

  // Results to x0, or to the register wb is overwriting right now, are consumed silently.
  assign accept_c   = md_valid & md_ready;
  assign enq_c      = accept_c & (md_rd != '0) & ~(wb_grant_c & (md_rd == wb_rd));
  assign enq_data_c = '{valid: 1'b1, rd: md_rd, value: md_value};

  md_fifo2 u_md_fifo2 (
    .clock    (clock),
    .reset    (reset),
    .enq      (enq_c),
    .enq_data (enq_data_c),
    .deq      (md_grant_c),
    .kill_en  (wb_grant_c),
    .kill_rd  (wb_rd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_comb begin
    write_c = '0;
    if (wb_grant_c) begin
      write_c = '{valid: 1'b1, rd: wb_rd, value: wb_value};
    end else if (md_grant_c) begin
      write_c = fifo_head;
    end
  end

  // Write port registers hold address/data between grants; counter tracks head losses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      starve_q         <= '0;
    end else begin
      ctrl_writeEnable <= write_c.valid;
      if (write_c.valid) begin
        ctrl_writeReg <= write_c.rd;
        data_writeReg <= write_c.value;
      end
      if (fifo_empty || md_grant_c) begin
        starve_q <= '0;
      end else if (starve_q != CNT_MAX) begin
        starve_q <= starve_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int unsigned LIMIT = 3;

  logic        clock;
  logic        reset;
  logic        wb_we;
  logic        wb_nop;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_value;
  logic        md_ready;
  logic        stall_wb;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock            (clock),
    .reset            (reset),
    .wb_we            (wb_we),
    .wb_nop           (wb_nop),
    .wb_rd            (wb_rd),
    .wb_value         (wb_value),
    .md_valid         (md_valid),
    .md_rd            (md_rd),
    .md_value         (md_value),
    .md_ready         (md_ready),
    .stall_wb         (stall_wb),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
  } ment_t;

  typedef struct {
    logic        we;
    logic        nop;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mval;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_ready;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  ment_t       mq[$];
  int          starve;
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  logic s_ready;
  logic s_stall;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check combinational outputs vs model, advance model, check registers.
  task automatic cycle(input logic r, input logic we, input logic nop, input logic [4:0] rd,
                       input logic [31:0] val, input logic mv, input logic [4:0] mrd,
                       input logic [31:0] mval);
    logic  wbr, ne, frc, wb_win, md_win, acc, er;
    ment_t head;
    ment_t nent;
    ment_t keep[$];
    reset = r; wb_we = we; wb_nop = nop; wb_rd = rd; wb_value = val;
    md_valid = mv; md_rd = mrd; md_value = mval;
    #2;
    s_ready = md_ready;
    s_stall = stall_wb;
    wbr = we && !nop && (rd != 5'd0);
    ne  = mq.size() != 0;
    frc = r && ne && wbr && (starve >= int'(LIMIT));
    er  = r && (mq.size() < 2);
    chk("md_ready", 32'(md_ready), 32'(er));
    chk("stall_wb", 32'(stall_wb), 32'(frc));
    if (!r) begin
      mq.delete();
      starve = 0;
      m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0;
    end else begin
      wb_win = wbr && !frc;
      md_win = ne && !wb_win;
      acc    = mv && (mq.size() < 2);
      if (md_win) begin
        head   = mq.pop_front();
        m_we   = 1'b1;
        m_reg  = head.rd;
        m_data = head.value;
      end else if (wb_win) begin
        m_we   = 1'b1;
        m_reg  = rd;
        m_data = val;
        keep = {};
        foreach (mq[i]) if (mq[i].rd != rd) keep.push_back(mq[i]);
        mq = keep;
      end else begin
        m_we = 1'b0;
      end
      if (ne && !md_win) starve = (starve + 1 > int'(LIMIT)) ? int'(LIMIT) : starve + 1;
      else               starve = 0;
      if (acc && (mrd != 5'd0) && !(wb_win && (mrd == rd))) begin
        nent.rd = mrd;
        nent.value = mval;
        mq.push_back(nent);
      end
    end
    @(posedge clock);
    #1;
    chk("ctrl_writeEnable", 32'(ctrl_writeEnable), 32'(m_we));
    chk("ctrl_writeReg", 32'(ctrl_writeReg), 32'(m_reg));
    chk("data_writeReg", data_writeReg, m_data);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,     1'b1, 5'd5, 32'hDEADBEEF, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 5'd0, 32'd0,       1'b0, 5'd0, 32'd0,     1'b0, 5'd5, 32'hDEADBEEF, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 5'd0, 32'd0,       1'b1, 5'd7, 32'h12,    1'b0, 5'd5, 32'hDEADBEEF, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'd0,       1'b0, 5'd0, 32'd0,     1'b1, 5'd7, 32'h12,       1'b1};
    tbl[4]  = '{1'b1, 1'b1, 5'd3, 32'h33,      1'b0, 5'd0, 32'd0,     1'b0, 5'd7, 32'h12,       1'b1};
    tbl[5]  = '{1'b1, 1'b0, 5'd0, 32'h66,      1'b0, 5'd0, 32'd0,     1'b0, 5'd7, 32'h12,       1'b1};
    tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'd0,       1'b1, 5'd0, 32'h55,    1'b0, 5'd7, 32'h12,       1'b1};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'd0,       1'b0, 5'd0, 32'd0,     1'b0, 5'd7, 32'h12,       1'b1};
    tbl[8]  = '{1'b1, 1'b0, 5'd4, 32'hAAAA,    1'b1, 5'd4, 32'hBBBB,  1'b1, 5'd4, 32'hAAAA,     1'b1};
    tbl[9]  = '{1'b0, 1'b0, 5'd0, 32'd0,       1'b0, 5'd0, 32'd0,     1'b0, 5'd4, 32'hAAAA,     1'b1};
    tbl[10] = '{1'b1, 1'b0, 5'd6, 32'h1,       1'b1, 5'd8, 32'h88,    1'b1, 5'd6, 32'h1,        1'b1};
    tbl[11] = '{1'b0, 1'b0, 5'd0, 32'd0,       1'b0, 5'd0, 32'd0,     1'b1, 5'd8, 32'h88,       1'b1};

    reset = 1'b0; wb_we = 1'b0; wb_nop = 1'b0; wb_rd = 5'd0; wb_value = 32'd0;
    md_valid = 1'b0; md_rd = 5'd0; md_value = 32'd0;
    mq.delete(); starve = 0; m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0;
    @(posedge clock);
    #1;

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd1);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("rst_reg", 32'(ctrl_writeReg), 32'd0);
    chk("rst_data", data_writeReg, 32'd0);

    // Vector table, starting in the first cycle after reset release
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, tbl[i].we, tbl[i].nop, tbl[i].rd, tbl[i].val,
            tbl[i].mv, tbl[i].mrd, tbl[i].mval);
      chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_we", i), 32'(ctrl_writeEnable), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_reg", i), 32'(ctrl_writeReg), 32'(tbl[i].e_reg));
      chk($sformatf("tbl%0d_data", i), data_writeReg, tbl[i].e_data);
    end

    // Starvation: buffered rd 9 under continuous wb to rd 3
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h300, 1'b1, 5'd9, 32'h99);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h300 + 32'(i), 1'b0, 5'd0, 32'd0);
      chk("starve_wb_stall", 32'(s_stall), 32'd0);
      chk("starve_wb_reg", 32'(ctrl_writeReg), 32'd3);
    end
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h304, 1'b0, 5'd0, 32'd0);
    chk("forced_stall", 32'(s_stall), 32'd1);
    chk("forced_reg", 32'(ctrl_writeReg), 32'd9);
    chk("forced_data", data_writeReg, 32'h99);
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h304, 1'b0, 5'd0, 32'd0);
    chk("held_stall", 32'(s_stall), 32'd0);
    chk("held_reg", 32'(ctrl_writeReg), 32'd3);
    chk("held_data", data_writeReg, 32'h304);
    idle(1);

    // FIFO full backpressure
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h1, 1'b1, 5'd10, 32'hA0);
    chk("full_rdy0", 32'(s_ready), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h2, 1'b1, 5'd11, 32'hB0);
    chk("full_rdy1", 32'(s_ready), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'(i) + 32'h1, 1'b1, 5'd12, 32'hC0);
      chk($sformatf("full_rdy%0d", i), 32'(s_ready), 32'd0);
    end
    chk("full_forced_reg", 32'(ctrl_writeReg), 32'd10);
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h5, 1'b1, 5'd12, 32'hC0);
    chk("full_rdy5", 32'(s_ready), 32'd1);
    idle(1);
    chk("drain_reg11", 32'(ctrl_writeReg), 32'd11);
    chk("drain_data11", data_writeReg, 32'hB0);
    idle(1);
    chk("drain_reg12", 32'(ctrl_writeReg), 32'd12);
    chk("drain_data12", data_writeReg, 32'hC0);
    idle(1);

    // WAW: buffered rd 4 superseded by wb write to rd 4
    cycle(1'b1, 1'b1, 1'b0, 5'd2, 32'h22, 1'b1, 5'd4, 32'h4D);
    cycle(1'b1, 1'b1, 1'b0, 5'd4, 32'h4444, 1'b0, 5'd0, 32'd0);
    chk("waw_reg", 32'(ctrl_writeReg), 32'd4);
    chk("waw_data", data_writeReg, 32'h4444);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("waw_no_md_write", 32'(ctrl_writeEnable), 32'd0);
    end

    // Reset with two buffered entries
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h7, 1'b1, 5'd13, 32'hD0);
    cycle(1'b1, 1'b1, 1'b0, 5'd3, 32'h8, 1'b1, 5'd14, 32'hE0);
    cycle(1'b0, 1'b1, 1'b0, 5'd3, 32'h9, 1'b1, 5'd15, 32'hF0);
    chk("mid_rst_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_stall", 32'(s_stall), 32'd0);
    chk("mid_rst_we", 32'(ctrl_writeEnable), 32'd0);
    chk("mid_rst_reg", 32'(ctrl_writeReg), 32'd0);
    chk("mid_rst_data", data_writeReg, 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("post_rst_no_write", 32'(ctrl_writeEnable), 32'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 7)),
            $urandom,
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 7)),
            $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
